// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, FSM state encoding and saturation limits for the Booth MAC accumulator.
package booth_pkg;
    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
endpackage

// File: rtl/sat_add.sv
// sat_add: signed W-bit saturating adder.
// Ports: a, b - signed operands; sum - clamped result; ovf - a clamp was applied.
module sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    logic [W:0] s;
    // One guard bit: the top two bits differ exactly when the true sum leaves the W-bit range.
    assign s   = {a[W-1], a} + {b[W-1], b};
    assign ovf = s[W] ^ s[W-1];
    assign sum = ovf ? (s[W] ? MIN : MAX) : s[W-1:0];
endmodule

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: framed saturating accumulator for Booth multiplier products.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/prod/last - product beat stream;
//        clr - synchronous frame abort; out_valid/out_ready/acc_out/cnt/sat - frame result.
module booth_mac_acc import booth_pkg::*; #(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              last,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [7:0]        cnt,
    output logic              sat
);
    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n, base, sum;
    logic [7:0]       cnt_r, cnt_n, cnt_base;
    logic             sat_r, sat_n, ovf, beat, fresh;

    assign in_ready  = rst_n && state != HOLD;
    assign out_valid = state == HOLD;
    assign beat      = in_valid && in_ready;
    // A beat in IDLE, or together with clr, opens a new frame from zero.
    assign fresh     = state == IDLE || clr;
    assign base      = fresh ? '0 : acc;
    assign cnt_base  = fresh ? 8'd0 : cnt_r;

    sat_add #(.W(ACC_W)) u_add (
        .a  (base),
        .b  ({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod}),
        .sum(sum),
        .ovf(ovf)
    );

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt_r;
        sat_n   = sat_r;
        if (state == HOLD) begin
            if (out_ready) begin
                state_n = IDLE;
                acc_n   = '0;
                cnt_n   = '0;
                sat_n   = 1'b0;
            end
        end else if (beat) begin
            state_n = last ? HOLD : ACC;
            acc_n   = sum;
            cnt_n   = cnt_base == 8'hFF ? 8'hFF : cnt_base + 8'd1;
            sat_n   = (sat_r && !fresh) || ovf;
        end else if (clr) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            sat_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt_r <= '0;
            sat_r <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt_r <= cnt_n;
            sat_r <= sat_n;
        end
    end

    assign acc_out = acc;
    assign cnt     = cnt_r;
    assign sat     = sat_r;
endmodule

// File: tb/tb_booth_mac_acc.sv
// tb_booth_mac_acc: directed and randomized checks of booth_mac_acc against an arithmetic model.
module tb_booth_mac_acc;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, last, clr, out_valid, out_ready, sat;
    logic [15:0] prod;
    logic [23:0] acc_out;
    logic [7:0]  cnt;
    int          tests = 0;
    int          fails = 0;

    booth_mac_acc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prod     (prod),
        .last     (last),
        .clr      (clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc_out  (acc_out),
        .cnt      (cnt),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is transferred.
    task automatic beat(input logic [15:0] p, input logic l);
        int k = 0;
        while (!in_ready && k < 10) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            fails++;
            $display("FAIL beat_ready in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1;
        prod     = p;
        last     = l;
        tick();
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; prod = '0; last = 1'b0; clr = 1'b0; out_ready = 1'b1;
        #2;
        tests++;
        if ({in_ready, out_valid, acc_out, cnt, sat} !== 35'd0) begin
            fails++;
            $display("FAIL reset_outputs got rdy=%b ov=%b acc=%h cnt=%0d sat=%b expected all zero",
                     in_ready, out_valid, acc_out, cnt, sat);
        end
        #5 rst_n = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got rdy=%b ov=%b expected rdy=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        beat(16'h0064, 0); beat(16'hFF9C, 0); beat(16'h0005, 1);
        tests++;
        if ({out_valid, acc_out, cnt, sat} !== {1'b1, 24'h000005, 8'd3, 1'b0}) begin
            fails++;
            $display("FAIL basic_result got ov=%b acc=%h cnt=%0d sat=%b expected ov=1 acc=000005 cnt=3 sat=0",
                     out_valid, acc_out, cnt, sat);
        end
        tick();
        tests++;
        if ({out_valid, in_ready, acc_out, cnt} !== {1'b0, 1'b1, 24'h0, 8'd0}) begin
            fails++;
            $display("FAIL basic_idle got ov=%b rdy=%b acc=%h cnt=%0d expected ov=0 rdy=1 acc=0 cnt=0",
                     out_valid, in_ready, acc_out, cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 600; i++) beat(16'h4000, i == 599);
        tests++;
        if ({out_valid, acc_out, cnt, sat} !== {1'b1, 24'h7FFFFF, 8'd255, 1'b1}) begin
            fails++;
            $display("FAIL sat_pos got ov=%b acc=%h cnt=%0d sat=%b expected ov=1 acc=7fffff cnt=255 sat=1",
                     out_valid, acc_out, cnt, sat);
        end
        tick();
        for (int i = 0; i < 600; i++) beat(16'hC000, i == 599);
        tests++;
        if ({out_valid, acc_out, cnt, sat} !== {1'b1, 24'h800000, 8'd255, 1'b1}) begin
            fails++;
            $display("FAIL sat_neg got ov=%b acc=%h cnt=%0d sat=%b expected ov=1 acc=800000 cnt=255 sat=1",
                     out_valid, acc_out, cnt, sat);
        end
        tick();
        tests++;
        if (sat !== 1'b0) begin
            fails++;
            $display("FAIL sat_cleared got sat=%b expected 0", sat);
        end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        beat(16'hFFFF, 1);
        in_valid = 1'b1;
        prod     = 16'h0007;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({out_valid, in_ready, acc_out, cnt} !== {1'b1, 1'b0, 24'hFFFFFF, 8'd1}) begin
                fails++;
                $display("FAIL hold_stable cycle %0d got ov=%b rdy=%b acc=%h cnt=%0d expected ov=1 rdy=0 acc=ffffff cnt=1",
                         i, out_valid, in_ready, acc_out, cnt);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if ({in_ready, out_valid, cnt} !== {1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL hold_release got rdy=%b ov=%b cnt=%0d expected rdy=1 ov=0 cnt=0",
                     in_ready, out_valid, cnt);
        end
    endtask

    task automatic test_clr();
        beat(16'h0010, 0); beat(16'h0020, 0);
        clr = 1'b1;
        beat(16'h0003, 0);
        clr = 1'b0;
        beat(16'h0001, 1);
        tests++;
        if ({out_valid, acc_out, cnt} !== {1'b1, 24'h000004, 8'd2}) begin
            fails++;
            $display("FAIL clr_with_beat got ov=%b acc=%h cnt=%0d expected ov=1 acc=000004 cnt=2",
                     out_valid, acc_out, cnt);
        end
        tick();
        beat(16'h0009, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tests++;
        if ({in_ready, acc_out, cnt} !== {1'b1, 24'h0, 8'd0}) begin
            fails++;
            $display("FAIL clr_alone got rdy=%b acc=%h cnt=%0d expected rdy=1 acc=0 cnt=0", in_ready, acc_out, cnt);
        end
    endtask

    task automatic test_async_reset();
        beat(16'h0010, 0); beat(16'h0020, 0);
        tests++;
        if (acc_out !== 24'h000030) begin
            fails++;
            $display("FAIL arst_pre got acc=%h expected 000030", acc_out);
        end
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, out_valid, acc_out, cnt, sat} !== 35'd0) begin
            fails++;
            $display("FAIL arst_immediate got rdy=%b ov=%b acc=%h cnt=%0d sat=%b expected all zero",
                     in_ready, out_valid, acc_out, cnt, sat);
        end
        #2 rst_n = 1'b1;
        tick();
        beat(16'h0007, 1);
        tests++;
        if ({out_valid, acc_out, cnt} !== {1'b1, 24'h000007, 8'd1}) begin
            fails++;
            $display("FAIL arst_next_frame got ov=%b acc=%h cnt=%0d expected ov=1 acc=000007 cnt=1",
                     out_valid, acc_out, cnt);
        end
        tick();
    endtask

    task automatic test_clr_hold();
        out_ready = 1'b0;
        beat(16'h0005, 1);
        clr = 1'b1;
        tick(); tick(); tick();
        clr = 1'b0;
        tests++;
        if ({out_valid, acc_out, cnt} !== {1'b1, 24'h000005, 8'd1}) begin
            fails++;
            $display("FAIL clr_in_hold got ov=%b acc=%h cnt=%0d expected ov=1 acc=000005 cnt=1",
                     out_valid, acc_out, cnt);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL clr_hold_consume got ov=%b expected 0", out_valid);
        end
    endtask

    // Reference: exact running sum clamped to the 24-bit signed range after every beat.
    task automatic test_random();
        for (int f = 0; f < 24; f++) begin
            int          mode = $urandom_range(0, 2);
            int          n = (mode == 0) ? $urandom_range(1, 10) : $urandom_range(150, 300);
            longint      s = 0;
            bit          sx = 0;
            logic [15:0] p;
            out_ready = 1'b0;
            for (int i = 0; i < n; i++) begin
                p = (mode == 0) ? 16'($urandom) : (mode == 1) ? (16'h6000 | 16'($urandom_range(0, 8191)))
                                                              : (16'h8000 | 16'($urandom_range(0, 8191)));
                s = s + longint'($signed(p));
                if (s > 64'sd8388607) begin s = 8388607; sx = 1; end
                if (s < -64'sd8388608) begin s = -8388608; sx = 1; end
                if ($urandom_range(0, 3) == 0) tick();
                beat(p, i == n - 1);
            end
            tests++;
            if ({out_valid, acc_out, cnt, sat} !== {1'b1, 24'(s), 8'(n > 255 ? 255 : n), sx}) begin
                fails++;
                $display("FAIL random_frame %0d got ov=%b acc=%h cnt=%0d sat=%b expected ov=1 acc=%h cnt=%0d sat=%b",
                         f, out_valid, acc_out, cnt, sat, 24'(s), n > 255 ? 255 : n, sx);
            end
            repeat ($urandom_range(0, 3)) tick();
            out_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_hold();
        test_clr();
        test_async_reset();
        test_clr_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
